// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared definitions for the multicycle RV32 subset controller:
//   FSM state encodings, the opcodes the controller decodes, ALU
//   operation codes, ALU B-input select codes and the ALU decode classes
//   used by alu_decoder.
package multicycle_control_pkg;

  // Encodings are visible on the debug 'state' port, so they are fixed.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    WB_MEM    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    I_EXEC    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // What kind of ALU operation the current state wants:
  // a fixed add, a fixed subtract, or one chosen by the funct fields.
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_class_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder
//   Combinational ALU operation decoder.
//   Ports:
//     alu_class   in  : operation class requested by the current FSM state
//     funct3      in  : IR[14:12]
//     funct7_5    in  : IR[30]
//     alu_control out : ALU operation code
//     funct_legal out : funct3/funct7_5 name a supported R-type operation
//   funct_legal does not depend on alu_class so the FSM can use it for
//   legality checking in DECODE while the ALU is doing a plain add.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output logic [3:0]  alu_control,
  output logic        funct_legal
);

  logic [3:0] funct_alu;

  always_comb begin
    funct_legal = 1'b0;
    funct_alu   = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: begin
        funct_legal = 1'b1;
        funct_alu   = funct7_5 ? ALU_SUB : ALU_ADD;
      end
      F3_AND: begin
        funct_legal = 1'b1;
        funct_alu   = ALU_AND;
      end
      F3_OR: begin
        funct_legal = 1'b1;
        funct_alu   = ALU_OR;
      end
      default: begin
        funct_legal = 1'b0;
        funct_alu   = ALU_ADD;
      end
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ALU_CLS_SUB:   alu_control = ALU_SUB;
      ALU_CLS_FUNCT: alu_control = funct_alu;
      default:       alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle RV32 subset
//   (lw, sw, add, sub, and, or, addi, beq).
//   Ports:
//     clk, reset_n         : clock (rising edge), async active-low reset
//     opcode/funct3/funct7_5 : instruction register fields
//     zero                 : ALU zero flag for the current cycle
//     PCWrite .. alu_control : datapath enables and mux selects
//     state                : current FSM state (debug)
//     illegal_op           : unsupported instruction seen in DECODE
//     instret              : retired instruction counter (wraps)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned COUNTER_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 PCSource,
  output logic                 regWrite,
  output logic [3:0]           alu_control,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [COUNTER_W-1:0] instret
);

  state_t                 state_q, state_d;
  logic [COUNTER_W-1:0]   instret_q, instret_d;
  logic                   decode_illegal;
  logic                   retire;

  alu_class_t             alu_class;
  logic [3:0]             dec_alu_control;
  logic                   funct_legal;

  always_comb begin
    alu_class = ALU_CLS_ADD;
    if (state_q == R_EXEC) begin
      alu_class = ALU_CLS_FUNCT;
    end else if (state_q == BRANCH) begin
      alu_class = ALU_CLS_SUB;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu_control),
    .funct_legal (funct_legal)
  );

  // Next state, DECODE legality and retirement.
  always_comb begin
    state_d        = FETCH;
    decode_illegal = 1'b0;
    retire         = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_RTYPE: begin
            if (funct_legal) state_d = R_EXEC;
            else             decode_illegal = 1'b1;
          end
          OP_IMM: begin
            if (funct3 == F3_ADD_SUB) state_d = I_EXEC;
            else                      decode_illegal = 1'b1;
          end
          OP_BRANCH: begin
            if (funct3 == F3_ADD_SUB) state_d = BRANCH;
            else                      decode_illegal = 1'b1;
          end
          default: decode_illegal = 1'b1;
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = WB_MEM;
      WB_MEM: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEM_WRITE: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      R_EXEC:    state_d = ALU_WB;
      I_EXEC:    state_d = ALU_WB;
      ALU_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default:   state_d = FETCH;
    endcase

    instret_d = retire ? instret_q + COUNTER_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Controls decode straight from state rather than from a register so the
  // FETCH actions are live in the very first cycle after reset release.
  // Holding reset gates everything to 0 so no write can slip out while the
  // FSM sits in FETCH under reset.
  always_comb begin
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = 1'b0;
    regWrite    = 1'b0;
    alu_control = dec_alu_control;
    illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      DECODE: begin
        PCWrite    = 1'b1;
        PCSource   = 1'b1;
        ALUSrcB    = SRCB_IMM;
        illegal_op = decode_illegal;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_READ: begin
        memRead = 1'b1;
        IorD    = 1'b1;
      end
      WB_MEM: begin
        regWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
      end
      R_EXEC: ALUSrcA = 1'b1;
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ALU_WB: regWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        PCSource = 1'b1;
        PCWrite  = zero;
      end
      default: alu_control = 4'b0000;
    endcase

    if (!reset_n) begin
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 1'b0;
      regWrite    = 1'b0;
      alu_control = 4'b0000;
      illegal_op  = 1'b0;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed, table-driven bench for multicycle_control. Each table record
//   is one instruction with its expected state walk; per-state controls
//   come from a hand-written table. A narrow counter width makes the
//   instret wrap reachable in a short run.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7_5 = 1'b0;
  logic          zero = 1'b0;
  logic          PCWrite, IorD, memRead, memWrite, IRWrite, MemtoReg;
  logic          ALUSrcA, PCSource, regWrite, illegal_op;
  logic [1:0]    ALUSrcB;
  logic [3:0]    alu_control, state;
  logic [CW-1:0] instret;

  typedef struct packed {
    logic       pc_write;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic       reg_write;
    logic [3:0] alu_control;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    string      seq;
    logic [3:0] rexec_alu;
    logic       illegal;
    logic       retire;
  } vec_t;

  ctrl_t         act_ctrl;
  vec_t          vecs [13];
  logic [CW-1:0] exp_instret = '0;
  int            total = 0;
  int            bad = 0;

  assign act_ctrl = {PCWrite, IorD, memRead, memWrite, IRWrite, MemtoReg,
                     ALUSrcA, ALUSrcB, PCSource, regWrite, alu_control};

  multicycle_control #(.COUNTER_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .regWrite    (regWrite),
    .alu_control (alu_control),
    .state       (state),
    .illegal_op  (illegal_op),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected controls per state, straight from the state action list.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st,
                                     input logic [3:0] rexec_alu,
                                     input logic zero_in);
    ctrl_t c;
    c = '0;
    c.alu_control = 4'b0010;
    case (st)
      4'd0: begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01; end
      4'd1: begin c.pc_write = 1'b1; c.pc_source = 1'b1; c.alu_src_b = 2'b10; end
      4'd2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3: begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
      4'd4: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      4'd5: begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
      4'd6: begin c.alu_src_a = 1'b1; c.alu_control = rexec_alu; end
      4'd7: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd8: begin c.reg_write = 1'b1; end
      4'd9: begin
        c.alu_src_a = 1'b1; c.alu_control = 4'b0110;
        c.pc_source = 1'b1; c.pc_write = zero_in;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s %s: got %0h want %0h", tag, what, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] exp_state,
                              input ctrl_t exp_c, input logic exp_ill);
    check(tag, "state", 32'(state), 32'(exp_state));
    check(tag, "ctrl", 32'(act_ctrl), 32'(exp_c));
    check(tag, "illegal_op", 32'(illegal_op), 32'(exp_ill));
    check(tag, "instret", 32'(instret), 32'(exp_instret));
  endtask

  // Runs the first 'stop_at' cycles of an instruction starting at a falling
  // edge in FETCH; a full run credits the expected retirement.
  task automatic apply_stimulus(input vec_t v, input int stop_at);
    logic [3:0] st;
    opcode   = v.opcode;
    funct3   = v.funct3;
    funct7_5 = v.funct7_5;
    zero     = v.zero;
    for (int c = 0; c < stop_at; c++) begin
      st = 4'(v.seq[c] - 8'd48);
      #1;
      check_output($sformatf("%s[c%0d]", v.name, c), st,
                   exp_ctrl(st, v.rexec_alu, v.zero),
                   (st == 4'd1) && v.illegal);
      @(negedge clk);
    end
    if (stop_at == v.seq.len() && v.retire) exp_instret = exp_instret + 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"addi",   7'b0010011, 3'b000, 1'b0, 1'b0, "0178",  4'b0010, 1'b0, 1'b1};
    vecs[1]  = '{"lw",     7'b0000011, 3'b010, 1'b0, 1'b1, "01234", 4'b0010, 1'b0, 1'b1};
    vecs[2]  = '{"sw",     7'b0100011, 3'b010, 1'b0, 1'b0, "0125",  4'b0010, 1'b0, 1'b1};
    vecs[3]  = '{"add",    7'b0110011, 3'b000, 1'b0, 1'b0, "0168",  4'b0010, 1'b0, 1'b1};
    vecs[4]  = '{"sub",    7'b0110011, 3'b000, 1'b1, 1'b0, "0168",  4'b0110, 1'b0, 1'b1};
    vecs[5]  = '{"and",    7'b0110011, 3'b111, 1'b0, 1'b0, "0168",  4'b0000, 1'b0, 1'b1};
    vecs[6]  = '{"or",     7'b0110011, 3'b110, 1'b0, 1'b0, "0168",  4'b0001, 1'b0, 1'b1};
    vecs[7]  = '{"beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, "019",   4'b0010, 1'b0, 1'b1};
    vecs[8]  = '{"beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, "019",   4'b0010, 1'b0, 1'b1};
    vecs[9]  = '{"ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0, "01",    4'b0010, 1'b1, 1'b0};
    vecs[10] = '{"ill_r",  7'b0110011, 3'b100, 1'b0, 1'b0, "01",    4'b0010, 1'b1, 1'b0};
    vecs[11] = '{"ill_i",  7'b0010011, 3'b010, 1'b0, 1'b0, "01",    4'b0010, 1'b1, 1'b0};
    vecs[12] = '{"ill_b",  7'b1100011, 3'b001, 1'b0, 1'b0, "01",    4'b0010, 1'b1, 1'b0};

    // Held in reset across several edges: everything quiet, state FETCH.
    opcode = 7'b0110011;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("reset", 4'd0, '0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) apply_stimulus(vecs[i], vecs[i].seq.len());

    // Nine retirements so far; six more addi bring the counter to its top.
    for (int i = 0; i < 6; i++) apply_stimulus(vecs[0], 4);
    #1;
    check("wrap", "instret_top", 32'(instret), 32'h0000000F);
    apply_stimulus(vecs[0], 4);
    #1;
    check("wrap", "instret_zero", 32'(instret), 32'h00000000);

    // Abort a store in MEM_WRITE with reset: write must vanish immediately.
    apply_stimulus(vecs[0], 4);
    apply_stimulus(vecs[2], 3);
    #1;
    check("sw_abort", "memWrite_before", 32'(memWrite), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    exp_instret = '0;
    check_output("sw_abort_now", 4'd0, '0, 1'b0);
    @(negedge clk);
    #1;
    check_output("sw_abort_held", 4'd0, '0, 1'b0);
    reset_n = 1'b1;
    apply_stimulus(vecs[0], 4);
    #1;
    check("post_reset", "instret", 32'(instret), 32'd1);
    check("post_reset", "state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
